// File: rtl/flappy_pkg.sv
// ============================================================================
// Module      : flappy_pkg
// Description : Shared FSM encodings, gap-height table, LFSR seed/taps and
//               spawn X position for the pipe obstacle logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flappy_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_LOST = 2'd2;

    localparam logic [7:0] c_LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 (1-based) map to bits 7,5,4,3.
    localparam logic [7:0] c_LFSR_TAPS = 8'b1011_1000;

    localparam logic [9:0] c_X_SPAWN = 10'd1000;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][9:0] c_PIPE_HEIGHTS = {
        10'd200, 10'd230, 10'd190, 10'd170,
        10'd250, 10'd210, 10'd100, 10'd300
    };

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & c_LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot_arbiter.sv
// ============================================================================
// Module      : pipe_slot_arbiter
// Description : Combinational round-robin arbiter; grants the first requesting
//               slot at or after the pointer, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot_arbiter #(
    parameter int NUM_PIPES = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PIPES-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PIPES-1:0] o_grant,
    output logic [PTR_W-1:0]     o_grant_idx,
    output logic                 o_any
);

    // Outer loop walks priority order from the pointer; inner loop keeps
    // every bit select constant.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            for (int s = 0; s < NUM_PIPES; s++) begin
                if (!o_any && i_req[s] && (((int'(i_ptr) + k) % NUM_PIPES) == s)) begin
                    o_any       = 1'b1;
                    o_grant[s]  = 1'b1;
                    o_grant_idx = PTR_W'(s);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_scheduler.sv
// ============================================================================
// Module      : pipe_scheduler
// Description : Pipe game sequencer: move tick, spawn cadence, gap height and
//               round-robin slot assignment. Optional tick speed-up enabled by
//               defining PIPE_SCHED_SPEEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES = 2,
    parameter int TICK_DIV  = 500000,
    parameter int SPAWN_GAP = 500,
    parameter int TICK_MIN  = 200000,
    parameter int TICK_STEP = 25000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Lost,
    input  logic [NUM_PIPES-1:0] PipeFree,
    output logic                 MoveTick,
    output logic [NUM_PIPES-1:0] Spawn,
    output logic [9:0]           SpawnY,
    output logic                 Running,
    output logic [7:0]           SpawnCnt
);

    localparam int                 c_PTR_W      = (NUM_PIPES > 2) ? 2 : 1;
    localparam logic [19:0]        c_TICK_DIV   = 20'(TICK_DIV);
    localparam logic [9:0]         c_GAP_RELOAD = 10'(SPAWN_GAP - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_SLOT  = c_PTR_W'(NUM_PIPES - 1);

    logic [1:0]           r_state;
    logic [19:0]          r_tick_cnt;
    logic [9:0]           r_gap_cnt;
    logic                 r_pending;
    logic [7:0]           r_lfsr;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic                 r_move_tick;
    logic [NUM_PIPES-1:0] r_spawn;
    logic [9:0]           r_spawn_y;
    logic                 r_running;
    logic [7:0]           r_spawn_cnt;

    logic [NUM_PIPES-1:0] w_grant;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic                 w_any;
    logic [19:0]          w_tick_div;
    logic                 w_wrap;
    logic                 w_gap_fire;
    logic                 w_grant_ok;

    pipe_slot_arbiter #(
        .NUM_PIPES (NUM_PIPES),
        .PTR_W     (c_PTR_W)
    ) u_arbiter (
        .i_req       (PipeFree),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // The gap counter acts on the same edge that raises MoveTick, so the
    // first spawn lands one cycle after the first MoveTick.
    assign w_wrap     = (r_tick_cnt == w_tick_div - 20'd1);
    assign w_gap_fire = w_wrap && (r_gap_cnt == 10'd0);
    assign w_grant_ok = r_pending && w_any;

`ifdef PIPE_SCHED_SPEEDUP_EN
    localparam logic [19:0] c_TICK_MIN  = 20'(TICK_MIN);
    localparam logic [19:0] c_TICK_STEP = 20'(TICK_STEP);

    logic [19:0] r_tick_div;
    logic [19:0] r_div_tgt;

    assign w_tick_div = r_tick_div;

    // r_div_tgt tracks the speed-up; r_tick_div only adopts it at a wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tick_div <= c_TICK_DIV;
            r_div_tgt  <= c_TICK_DIV;
        end else if (r_state == c_ST_IDLE && Start && !Lost) begin
            r_tick_div <= c_TICK_DIV;
            r_div_tgt  <= c_TICK_DIV;
        end else if (r_state == c_ST_RUN && !Lost) begin
            if (w_wrap)
                r_tick_div <= r_div_tgt;
            if (w_grant_ok && r_spawn_cnt != 8'hFF && r_spawn_cnt[2:0] == 3'd7)
                r_div_tgt <= (r_div_tgt >= c_TICK_MIN + c_TICK_STEP) ?
                             r_div_tgt - c_TICK_STEP : c_TICK_MIN;
        end
    end
`else
    logic [31:0] w_unused_cfg;

    assign w_tick_div   = c_TICK_DIV;
    assign w_unused_cfg = 32'(TICK_MIN) ^ 32'(TICK_STEP);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_tick_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_pending   <= 1'b0;
            r_lfsr      <= c_LFSR_SEED;
            r_rr_ptr    <= '0;
            r_move_tick <= 1'b0;
            r_spawn     <= '0;
            r_spawn_y   <= '0;
            r_running   <= 1'b0;
            r_spawn_cnt <= '0;
        end else begin
            r_lfsr      <= lfsr_next(r_lfsr);
            r_move_tick <= 1'b0;
            r_spawn     <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (Start && !Lost) begin
                        r_state     <= c_ST_RUN;
                        r_running   <= 1'b1;
                        r_tick_cnt  <= '0;
                        r_gap_cnt   <= '0;
                        r_pending   <= 1'b0;
                        r_spawn_cnt <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (Lost) begin
                        r_state   <= c_ST_LOST;
                        r_running <= 1'b0;
                        r_pending <= 1'b0;
                    end else begin
                        r_tick_cnt  <= w_wrap ? 20'd0 : r_tick_cnt + 20'd1;
                        r_move_tick <= w_wrap;
                        if (w_wrap)
                            r_gap_cnt <= (r_gap_cnt == 10'd0) ? c_GAP_RELOAD : r_gap_cnt - 10'd1;
                        if (w_grant_ok) begin
                            r_spawn   <= w_grant;
                            r_spawn_y <= c_PIPE_HEIGHTS[r_lfsr[2:0]];
                            r_rr_ptr  <= (w_grant_idx == c_LAST_SLOT) ? '0 : w_grant_idx + 1'b1;
                            if (r_spawn_cnt != 8'hFF)
                                r_spawn_cnt <= r_spawn_cnt + 8'd1;
                        end
                        // A fresh request wins over clearing the one just granted.
                        if (w_gap_fire)
                            r_pending <= 1'b1;
                        else if (w_grant_ok)
                            r_pending <= 1'b0;
                    end
                end
                c_ST_LOST: begin
                    if (!Start)
                        r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign MoveTick = r_move_tick;
    assign Spawn    = r_spawn;
    assign SpawnY   = r_spawn_y;
    assign Running  = r_running;
    assign SpawnCnt = r_spawn_cnt;

endmodule

`default_nettype wire
